// File: rtl/testio_wb_arbiter.sv
// testio_wb_arbiter: round-robin Wishbone arbiter in front of one testio master,
// with a watchdog that aborts a stuck transaction and soft-resets the master.
module testio_wb_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int BUS_WIDTH = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ-1:0]           req_cyc_i,
  input  logic [NUM_REQ-1:0]           req_stb_i,
  input  logic [NUM_REQ-1:0]           req_we_i,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]           req_ack_o,
  output logic [NUM_REQ-1:0]           req_err_o,
  output logic [31:0]                  req_rdata_o,
  output logic                         arb_testio_cyc_o,
  output logic                         arb_testio_stb_o,
  output logic                         arb_testio_we_o,
  output logic [BUS_WIDTH-1:0]         arb_testio_addr_o,
  output logic [BUS_WIDTH-1:0]         arb_testio_wdata_o,
  input  logic                         testio_arb_ack_i,
  input  logic [31:0]                  testio_arb_rdata_i,
  output logic                         testio_srst_o,
  output logic [NUM_REQ-1:0]           arb_grant_o,
  output logic                         arb_busy_o
);
  localparam int LW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {ARB_IDLE, ARB_CMD, ARB_RESP, ARB_ERR} state_t;
  state_t               state_q, state_d;
  logic [LW-1:0]        last_q, last_d, win;
  logic [TW-1:0]        timer_q, timer_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, req;
  logic                 we_q, we_d, found, g_cyc;
  logic [BUS_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;

  assign req   = req_cyc_i & req_stb_i;
  assign g_cyc = |(req_cyc_i & grant_q);

  always_comb begin
    found = 1'b0;
    win   = last_q;
    for (int k = 1; k <= NUM_REQ; k++)
      if (!found && req[(int'(last_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = LW'((int'(last_q) + k) % NUM_REQ);
      end
  end

  // In ARB_ERR the timer doubles as the first/second-cycle marker.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    timer_d = timer_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ARB_IDLE: if (found) begin
        state_d = ARB_CMD;
        last_d  = win;
        grant_d = NUM_REQ'(1) << win;
        timer_d = '0;
        we_d    = req_we_i[win];
        addr_d  = req_addr_i[int'(win)*BUS_WIDTH +: BUS_WIDTH];
        wdata_d = req_wdata_i[int'(win)*BUS_WIDTH +: BUS_WIDTH];
      end
      ARB_CMD: begin
        timer_d = timer_q + TW'(1);
        if (testio_arb_ack_i) begin
          rdata_d = testio_arb_rdata_i;
          state_d = ARB_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = ARB_ERR;
          timer_d = '0;
        end
      end
      ARB_RESP: if (!g_cyc) begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
      default: begin
        timer_d = (timer_q == '0) ? TW'(1) : '0;
        state_d = (timer_q == '0) ? ARB_ERR : ARB_IDLE;
        grant_d = (timer_q == '0) ? grant_q : '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
      last_q  <= LW'(NUM_REQ - 1);
      timer_q <= '0;
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign arb_testio_cyc_o   = (state_q == ARB_CMD) | ((state_q == ARB_RESP) & g_cyc);
  assign arb_testio_stb_o   = arb_testio_cyc_o;
  assign arb_testio_we_o    = we_q;
  assign arb_testio_addr_o  = addr_q;
  assign arb_testio_wdata_o = wdata_q;
  assign req_rdata_o        = rdata_q;
  assign req_ack_o          = (state_q == ARB_RESP && testio_arb_ack_i) ? grant_q & req_cyc_i : '0;
  assign req_err_o          = (state_q == ARB_ERR && timer_q == '0) ? grant_q & req_cyc_i : '0;
  assign testio_srst_o      = state_q == ARB_ERR;
  assign arb_grant_o        = grant_q;
  assign arb_busy_o         = state_q != ARB_IDLE;
endmodule

// File: tb/tb_testio_wb_arbiter.sv
// tb_testio_wb_arbiter: directed requesters and a testio slave model feeding a
// scoreboard of expected downstream commands, acks and errors.
module tb_testio_wb_arbiter;
  localparam int N = 2;
  localparam int W = 32;

  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; int ab;} cmd_t;
  typedef struct {logic [N-1:0] grant; logic we; logic [31:0] addr; logic [31:0] wdata;} exp_cmd_t;
  typedef struct {logic [N-1:0] vec; logic [31:0] rdata;} exp_ack_t;

  logic clk = 1'b0, rstn = 1'b0;
  logic [N-1:0] req_cyc_i = '0, req_stb_i = '0, req_we_i = '0;
  logic [N*W-1:0] req_addr_i = '0, req_wdata_i = '0;
  logic [N-1:0] req_ack_o, req_err_o, arb_grant_o;
  logic [31:0] req_rdata_o, rd_val = '0;
  logic arb_testio_cyc_o, arb_testio_stb_o, arb_testio_we_o, testio_srst_o, arb_busy_o;
  logic [W-1:0] arb_testio_addr_o, arb_testio_wdata_o;
  logic testio_arb_ack_i = 1'b0;

  int total = 0, bad = 0;
  cmd_t rq[N][$];
  exp_cmd_t cmdq[$];
  exp_ack_t ackq[$];
  logic [N-1:0] errq[$];
  exp_cmd_t cur;
  logic [N-1:0] drv_busy = '0, ack_seen = '0, err_seen = '0, prev_ack_o = '0;
  int gcnt[N], cur_ab[N];
  logic prev_cyc = 1'b0, prev_tack = 1'b0, no_ack = 1'b0;
  int scnt = 0, ack_dly = 5;

  always #5 clk = ~clk;

  testio_wb_arbiter #(.NUM_REQ(N), .BUS_WIDTH(W), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .req_cyc_i(req_cyc_i), .req_stb_i(req_stb_i), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ack_o(req_ack_o), .req_err_o(req_err_o), .req_rdata_o(req_rdata_o),
    .arb_testio_cyc_o(arb_testio_cyc_o), .arb_testio_stb_o(arb_testio_stb_o),
    .arb_testio_we_o(arb_testio_we_o), .arb_testio_addr_o(arb_testio_addr_o),
    .arb_testio_wdata_o(arb_testio_wdata_o),
    .testio_arb_ack_i(testio_arb_ack_i), .testio_arb_rdata_i(rd_val),
    .testio_srst_o(testio_srst_o), .arb_grant_o(arb_grant_o), .arb_busy_o(arb_busy_o)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(int i, logic we, logic [31:0] a, logic [31:0] d, int ab);
    cmd_t c;
    exp_cmd_t e;
    c.we = we; c.addr = a; c.wdata = d; c.ab = ab;
    rq[i].push_back(c);
    e.grant = N'(1 << i); e.we = we; e.addr = a; e.wdata = d;
    cmdq.push_back(e);
  endtask

  task automatic exp_ack(logic [N-1:0] v, logic [31:0] r);
    exp_ack_t e;
    e.vec = v; e.rdata = r;
    ackq.push_back(e);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((arb_busy_o || drv_busy != '0 || rq[0].size() != 0 || rq[1].size() != 0) && k < 300);
    if (k >= 300) begin
      total++; bad++;
      $display("FAIL idle_wait: busy=%0b want 0", arb_busy_o);
    end
  endtask

  task automatic wait_grant();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (arb_grant_o == '0 && k < 100);
    if (k >= 100) begin
      total++; bad++;
      $display("FAIL grant_wait: grant=%b want nonzero", arb_grant_o);
    end
  endtask

  // Requesters: hold cyc/stb until an ack or error was seen, or abandon after ab grant cycles.
  initial begin
    cmd_t c;
    for (int i = 0; i < N; i++) begin gcnt[i] = 0; cur_ab[i] = 0; end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (drv_busy[i]) begin
          if (arb_grant_o[i]) gcnt[i]++;
          if (ack_seen[i] || err_seen[i] || (cur_ab[i] > 0 && gcnt[i] == cur_ab[i])) begin
            req_cyc_i[i] = 1'b0; req_stb_i[i] = 1'b0; drv_busy[i] = 1'b0;
          end
        end else if (rq[i].size() != 0) begin
          c = rq[i].pop_front();
          req_we_i[i] = c.we;
          req_addr_i[i*W +: W] = c.addr;
          req_wdata_i[i*W +: W] = c.wdata;
          req_cyc_i[i] = 1'b1; req_stb_i[i] = 1'b1;
          drv_busy[i] = 1'b1; gcnt[i] = 0; cur_ab[i] = c.ab;
        end
      end
    end
  end

  // Testio master model: ack after ack_dly cycles of cyc, held until cyc drops.
  initial forever begin
    @(posedge clk); #2;
    if (arb_testio_cyc_o && rstn) begin
      scnt++;
      if (!no_ack && scnt >= ack_dly) testio_arb_ack_i = 1'b1;
    end else begin
      scnt = 0;
      testio_arb_ack_i = 1'b0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a command, ack or error.
  initial forever begin
    exp_ack_t ea;
    logic [N-1:0] ee;
    @(negedge clk);
    if (rstn) begin
      if (arb_testio_cyc_o && !prev_cyc) begin
        if (cmdq.size() == 0) check("cmd_unexpected", 64'(arb_grant_o), 64'(0));
        else begin
          cur = cmdq.pop_front();
          check("cmd_grant", 64'(arb_grant_o), 64'(cur.grant));
          check("cmd_we", 64'(arb_testio_we_o), 64'(cur.we));
          check("cmd_addr", 64'(arb_testio_addr_o), 64'(cur.addr));
          check("cmd_wdata", 64'(arb_testio_wdata_o), 64'(cur.wdata));
          check("cmd_stb", 64'(arb_testio_stb_o), 64'(1));
        end
      end else if (arb_testio_cyc_o)
        check("cmd_hold", {31'd0, arb_testio_we_o, arb_testio_addr_o}, {31'd0, cur.we, cur.addr});
      if (req_ack_o != '0) begin
        if (ackq.size() == 0) check("ack_unexpected", 64'(req_ack_o), 64'(0));
        else begin
          ea = ackq.pop_front();
          check("ack_vec", 64'(req_ack_o), 64'(ea.vec));
          check("ack_rdata", 64'(req_rdata_o), 64'(ea.rdata));
          check("ack_latency", 64'(prev_tack), 64'(1));
        end
      end
      if (req_err_o != '0) begin
        if (errq.size() == 0) check("err_unexpected", 64'(req_err_o), 64'(0));
        else begin
          ee = errq.pop_front();
          check("err_vec", 64'(req_err_o), 64'(ee));
          check("err_srst", 64'(testio_srst_o), 64'(1));
        end
      end
      if (prev_ack_o != '0 && (req_cyc_i & arb_grant_o) == '0)
        check("cyc_drop", 64'(arb_testio_cyc_o), 64'(0));
    end
    prev_cyc = arb_testio_cyc_o;
    prev_tack = testio_arb_ack_i;
    ack_seen = req_ack_o;
    err_seen = req_err_o;
    prev_ack_o = req_ack_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (2) @(negedge clk);
    check("rst_ctl", 64'({arb_testio_cyc_o, arb_testio_stb_o, arb_testio_we_o, req_ack_o, req_err_o,
                          testio_srst_o, arb_grant_o, arb_busy_o}), 64'(0));
    check("rst_addr", {arb_testio_addr_o, arb_testio_wdata_o}, 64'(0));
    check("rst_rdata", 64'(req_rdata_o), 64'(0));
    @(posedge clk); #1 rstn = 1'b1;
    // single write
    rd_val = 32'h0;
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    exp_ack(2'b01, 32'h0);
    wait_idle();
    // single read
    rd_val = 32'hA5A5_5A5A;
    issue(1, 1'b0, 32'h20, 32'h0, 0);
    exp_ack(2'b10, 32'hA5A5_5A5A);
    wait_idle();
    // round-robin: both queues full, expected order 0,1,0,1
    rd_val = 32'h0000_1234;
    issue(0, 1'b1, 32'h100, 32'h1111_1111, 0); exp_ack(2'b01, 32'h1234);
    issue(1, 1'b0, 32'h200, 32'h0, 0);         exp_ack(2'b10, 32'h1234);
    issue(0, 1'b1, 32'h104, 32'h2222_2222, 0); exp_ack(2'b01, 32'h1234);
    issue(1, 1'b1, 32'h204, 32'h3333_3333, 0); exp_ack(2'b10, 32'h1234);
    wait_idle();
    // abandon two cycles after grant
    issue(0, 1'b0, 32'h300, 32'h0, 2);
    wait_grant();
    repeat (2) @(negedge clk);
    check("abandon_cyc", 64'({arb_testio_cyc_o, req_cyc_i[0]}), 64'(2'b10));
    k = 0;
    while (!testio_arb_ack_i && k < 50) begin @(negedge clk); k++; end
    check("abandon_ack_seen", 64'(testio_arb_ack_i), 64'(1));
    @(negedge clk);
    check("abandon_resp", 64'({arb_busy_o, arb_testio_cyc_o, req_ack_o}), 64'(4'b1000));
    @(negedge clk);
    check("abandon_idle", 64'(arb_busy_o), 64'(0));
    wait_idle();
    // timeout
    no_ack = 1'b1;
    issue(0, 1'b1, 32'h400, 32'hCAFE_F00D, 0);
    errq.push_back(2'b01);
    wait_grant();
    k = 0;
    do begin @(negedge clk); k++; end while (req_err_o == '0 && k < 40);
    check("err_latency", 64'(k), 64'(16));
    no_ack = 1'b0;
    rd_val = 32'h55;
    issue(1, 1'b0, 32'h500, 32'h0, 0);         exp_ack(2'b10, 32'h55);
    issue(0, 1'b1, 32'h404, 32'h4444_4444, 0); exp_ack(2'b01, 32'h55);
    @(negedge clk);
    check("err_cycle2", 64'({testio_srst_o, req_err_o, arb_testio_cyc_o}), 64'(4'b1000));
    @(negedge clk);
    check("err_done", 64'({testio_srst_o, arb_busy_o}), 64'(0));
    wait_idle();
    // reset during ARB_CMD
    no_ack = 1'b1;
    rd_val = 32'h77;
    issue(0, 1'b1, 32'h600, 32'h600D, 0);
    wait_grant();
    @(negedge clk);
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ctl", 64'({arb_testio_cyc_o, arb_testio_stb_o, arb_testio_we_o, req_ack_o, req_err_o,
                              testio_srst_o, arb_grant_o, arb_busy_o}), 64'(0));
    check("mid_rst_addr", {arb_testio_addr_o, arb_testio_wdata_o}, 64'(0));
    check("mid_rst_rdata", 64'(req_rdata_o), 64'(0));
    begin
      exp_cmd_t e;
      e.grant = 2'b01; e.we = 1'b1; e.addr = 32'h600; e.wdata = 32'h600D;
      cmdq.push_back(e);
    end
    issue(1, 1'b0, 32'h700, 32'h0, 0);
    exp_ack(2'b01, 32'h77);
    exp_ack(2'b10, 32'h77);
    no_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rstn = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);
    check("cmdq_empty", 64'(cmdq.size()), 64'(0));
    check("ackq_empty", 64'(ackq.size()), 64'(0));
    check("errq_empty", 64'(errq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
